pwm_from_count: RTL and testbench
=================================

PWM_FROM_COUNT -- requirements
Module: pwm_from_count

Interface
REQ-001 Parameter N, default 4: width of the incoming count and duty values.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 q  input  N  free-running count from the upstream synchronous up-counter, wraps 2^N-1 -> 0.
REQ-005 enable  input  1  run request.
REQ-006 duty_in  input  N  new duty value, high-time in counts per period.
REQ-007 duty_valid  input  1  duty_in is valid.
REQ-008 duty_ready  output  1  block can accept duty_in.
REQ-009 pwm_out  output  1  registered PWM output.
REQ-010 wrap_pulse  output  1  one-cycle pulse on each detected wrap.
REQ-011 busy  output  1  high in ARM, RUN and STOP states.

Function
REQ-012 The block SHALL register q into q_d every cycle; wrap is true when q_d == 2^N-1 and q == 0; wrap_pulse SHALL be wrap registered (asserted the cycle after q shows 0).
REQ-013 The block SHALL hold active_duty and a one-entry pending buffer (pend_val, pend_full); duty_ready SHALL equal !pend_full.
REQ-014 On duty_valid && duty_ready, duty_in SHALL be captured; duty_valid with duty_ready low is ignored, with no loss of the held pending value.
REQ-015 On wrap, if pend_full, active_duty SHALL load pend_val and pend_full SHALL clear.
REQ-016 A handshake in the same cycle as wrap SHALL load duty_in directly into active_duty and leave pend_full clear (bypass).
REQ-017 States: IDLE, ARM, RUN, STOP.
REQ-018 IDLE -> ARM when enable is high; ARM -> RUN on wrap; ARM -> IDLE if enable falls before wrap.
REQ-019 RUN -> STOP when enable falls; STOP -> IDLE on wrap; STOP -> RUN if enable rises again before wrap.
REQ-020 In RUN and STOP, pwm_out SHALL be registered (q < active_duty), one cycle of latency from q; in IDLE and ARM, pwm_out SHALL be 0.
REQ-021 active_duty = 0 SHALL give pwm_out constantly low; active_duty = 2^N-1 SHALL give high for 2^N-1 counts and low for 1 count per period.
REQ-022 Duty updates SHALL be accepted in every state; active_duty SHALL change only at wrap, so no period is ever truncated.
REQ-023 Comparison is unsigned, N bits wide; no arithmetic overflow is possible.

Reset
REQ-024 While reset_n is low, and asynchronously on its fall: state = IDLE, q_d = 0, active_duty = 0, pend_full = 0, pwm_out = 0, wrap_pulse = 0, busy = 0, duty_ready = 1.
REQ-025 Reset mid-period SHALL discard pending and active duty; after release, the block SHALL re-arm on the next wrap.
REQ-026 Because q_d resets to 0, no false wrap SHALL be detected in the first cycle after release.

Configuration
REQ-027 With PWM_PERIOD_CNT_EN defined, the block SHALL add an output period_cnt[7:0]: it resets to 0, increments on every wrap while in RUN or STOP, and wraps 255 -> 0.
REQ-028 Without PWM_PERIOD_CNT_EN, the period_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification (N=4, upstream counter period 16 cycles)
REQ-029 Reset held, then released, with enable=0 -> pwm_out=0, busy=0, duty_ready=1 for 3 full periods; wrap_pulse still pulses every 16 cycles.
REQ-030 Load duty=5 while IDLE, then raise enable -> ARM until the first wrap, then pwm_out high for exactly 5 of every 16 cycles, lagging q by 1 cycle.
REQ-031 In RUN with duty=5, send duty 12 mid-period, then send 3 while duty_ready=0 -> current period keeps 5 high cycles, next period has 12, and the 3 is ignored.
REQ-032 Handshake duty=9 in the exact wrap cycle -> the next period is 9 high, and duty_ready stays 1.
REQ-033 Drop enable mid-period in RUN -> the period finishes, then IDLE and pwm_out=0; if enable is re-raised before the wrap, the block returns to RUN with no gap.
REQ-034 Assert reset_n low mid-period with duty=12 -> pwm_out falls immediately, active_duty=0; with PWM_PERIOD_CNT_EN, period_cnt=0 and counts 255 -> 0 after 256 periods.

Source files
------------

// File: rtl/pwm_from_count_if.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | pwm_from_count_if : duty-value valid/ready handshake bundle           |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface pwm_from_count_if #(
  parameter int N = 4
);
  logic [N-1:0] duty_in;
  logic         duty_valid;
  logic         duty_ready;

  modport master (output duty_in, output duty_valid, input  duty_ready);
  modport slave  (input  duty_in, input  duty_valid, output duty_ready);
endinterface
`default_nettype wire

// File: rtl/pwm_from_count.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | pwm_from_count : PWM generator driven by an external free-running     |
// | count; duty changes only at count wrap. Optional PWM_PERIOD_CNT_EN    |
// | adds an 8-bit count of completed periods (period_cnt).                |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module pwm_from_count #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N-1:0]     q,
  input  logic             enable,
  pwm_from_count_if.slave  duty,
  output logic             pwm_out,
  output logic             wrap_pulse,
  output logic             busy
`ifdef PWM_PERIOD_CNT_EN
  ,
  output logic [7:0]       period_cnt
`endif
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  localparam logic [N-1:0] CNT_MAX = '1;

  logic [1:0]   state_q, state_d;
  logic [N-1:0] q_prev_q, q_prev_d;
  logic [N-1:0] active_q, active_d;
  logic [N-1:0] pend_val_q, pend_val_d;
  logic         pend_full_q, pend_full_d;
  logic         pwm_out_q, pwm_out_d;
  logic         wrap_pulse_q, wrap_pulse_d;

  logic wrap;
  logic accept;
  logic running_d;

  assign wrap   = (q_prev_q == CNT_MAX) && (q == '0);
  assign accept = duty.duty_valid && !pend_full_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (enable) state_d = ST_ARM;
      ST_ARM: begin
        if (!enable)   state_d = ST_IDLE;
        else if (wrap) state_d = ST_RUN;
      end
      ST_RUN:  if (!enable) state_d = ST_STOP;
      ST_STOP: begin
        if (enable)    state_d = ST_RUN;
        else if (wrap) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A handshake coinciding with wrap bypasses the pending slot entirely.
  always_comb begin
    active_d    = active_q;
    pend_val_d  = pend_val_q;
    pend_full_d = pend_full_q;
    if (wrap) begin
      pend_full_d = 1'b0;
      if (accept)           active_d = duty.duty_in;
      else if (pend_full_q) active_d = pend_val_q;
    end else if (accept) begin
      pend_val_d  = duty.duty_in;
      pend_full_d = 1'b1;
    end
  end

  // Compare against next-state values so the new duty and state apply from q == 0.
  always_comb begin
    q_prev_d     = q;
    wrap_pulse_d = wrap;
    running_d    = (state_d == ST_RUN) || (state_d == ST_STOP);
    pwm_out_d    = running_d && (q < active_d);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      q_prev_q     <= '0;
      active_q     <= '0;
      pend_val_q   <= '0;
      pend_full_q  <= 1'b0;
      pwm_out_q    <= 1'b0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      q_prev_q     <= q_prev_d;
      active_q     <= active_d;
      pend_val_q   <= pend_val_d;
      pend_full_q  <= pend_full_d;
      pwm_out_q    <= pwm_out_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  assign duty.duty_ready = !pend_full_q;
  assign pwm_out         = pwm_out_q;
  assign wrap_pulse      = wrap_pulse_q;
  assign busy            = (state_q != ST_IDLE);

`ifdef PWM_PERIOD_CNT_EN
  logic [7:0] period_cnt_q, period_cnt_d;

  always_comb begin
    period_cnt_d = period_cnt_q;
    if (wrap && ((state_q == ST_RUN) || (state_q == ST_STOP)))
      period_cnt_d = period_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) period_cnt_q <= 8'd0;
    else          period_cnt_q <= period_cnt_d;
  end

  assign period_cnt = period_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pwm_from_count.sv
`timescale 1ns/1ps
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pwm_from_count : directed self-checking bench for pwm_from_count   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_pwm_from_count;

  logic       clk;
  logic       reset_n;
  logic [3:0] q;
  logic       enable;
  logic       pwm_out;
  logic       wrap_pulse;
  logic       busy;
`ifdef PWM_PERIOD_CNT_EN
  logic [7:0] period_cnt;
`endif

  logic [3:0] s_q;
  int tests_run;
  int tests_failed;

  pwm_from_count_if #(.N(4)) dif ();

  pwm_from_count #(.N(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .q          (q),
    .enable     (enable),
    .duty       (dif),
    .pwm_out    (pwm_out),
    .wrap_pulse (wrap_pulse),
    .busy       (busy)
`ifdef PWM_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  // One clock: s_q is the count the DUT sampled on this edge; q then advances.
  task automatic step();
    @(posedge clk);
    #1;
    s_q = q;
    q   = q + 4'd1;
  endtask

  // Advance until the next edge samples q == 0 (the wrap edge).
  task automatic align();
    int n;
    n = 0;
    while (q != 4'd0 && n < 20) begin
      step();
      n++;
    end
    if (q != 4'd0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL align: q=%0d want 0 within 20 cycles", q);
    end
  endtask

  task automatic run_period(output int highs, output int pulses);
    highs  = 0;
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (pwm_out === 1'b1)    highs++;
      if (wrap_pulse === 1'b1) pulses++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    dif.duty_in    = 4'd0;
    dif.duty_valid = 1'b0;
    q = 4'd0;
    repeat (3) step();
    tests_run++; if (pwm_out !== 1'b0) begin tests_failed++; $display("FAIL reset_pwm: got %b want 0", pwm_out); end
    tests_run++; if (wrap_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_wrap: got %b want 0", wrap_pulse); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (dif.duty_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", dif.duty_ready); end
    align();
    reset_n = 1'b1;
    step();
    tests_run++; if (wrap_pulse !== 1'b0) begin tests_failed++; $display("FAIL no_false_wrap: got %b want 0", wrap_pulse); end
  endtask

  task automatic test_idle();
    int pulses;
    align();
    for (int p = 0; p < 3; p++) begin
      pulses = 0;
      for (int i = 0; i < 16; i++) begin
        step();
        if (wrap_pulse === 1'b1) pulses++;
        tests_run++; if (pwm_out !== 1'b0) begin tests_failed++; $display("FAIL idle_pwm: got %b want 0 (q=%0d)", pwm_out, s_q); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy: got %b want 0", busy); end
        tests_run++; if (dif.duty_ready !== 1'b1) begin tests_failed++; $display("FAIL idle_ready: got %b want 1", dif.duty_ready); end
      end
      tests_run++; if (pulses != 1) begin tests_failed++; $display("FAIL idle_wrap_count: got %0d want 1 per period", pulses); end
    end
  endtask

  task automatic test_run();
    int highs;
    repeat (3) step();
    dif.duty_in = 4'd5; dif.duty_valid = 1'b1;
    step();
    dif.duty_valid = 1'b0;
    tests_run++; if (dif.duty_ready !== 1'b0) begin tests_failed++; $display("FAIL run_pending: ready=%b want 0", dif.duty_ready); end
    enable = 1'b1;
    step();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL arm_busy: got %b want 1", busy); end
    align();
    tests_run++; if (pwm_out !== 1'b0) begin tests_failed++; $display("FAIL arm_pwm: got %b want 0", pwm_out); end
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (pwm_out === 1'b1) highs++;
      tests_run++; if (pwm_out !== (s_q < 4'd5)) begin tests_failed++; $display("FAIL run_lag: q=%0d pwm=%b want %b", s_q, pwm_out, (s_q < 4'd5)); end
    end
    tests_run++; if (highs != 5) begin tests_failed++; $display("FAIL run_duty5: highs=%0d want 5", highs); end
    tests_run++; if (dif.duty_ready !== 1'b1) begin tests_failed++; $display("FAIL run_ready: got %b want 1", dif.duty_ready); end
  endtask

  task automatic test_update();
    int highs, pulses;
    highs = 0;
    for (int i = 0; i < 4; i++) begin step(); if (pwm_out === 1'b1) highs++; end
    dif.duty_in = 4'd12; dif.duty_valid = 1'b1;
    step(); if (pwm_out === 1'b1) highs++;
    dif.duty_valid = 1'b0;
    tests_run++; if (dif.duty_ready !== 1'b0) begin tests_failed++; $display("FAIL upd_accept12: ready=%b want 0", dif.duty_ready); end
    dif.duty_in = 4'd3; dif.duty_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin step(); if (pwm_out === 1'b1) highs++; end
    tests_run++; if (dif.duty_ready !== 1'b0) begin tests_failed++; $display("FAIL upd_hold: ready=%b want 0", dif.duty_ready); end
    dif.duty_valid = 1'b0;
    for (int i = 0; i < 9; i++) begin step(); if (pwm_out === 1'b1) highs++; end
    tests_run++; if (highs != 5) begin tests_failed++; $display("FAIL upd_cur_period: highs=%0d want 5", highs); end
    run_period(highs, pulses);
    tests_run++; if (highs != 12) begin tests_failed++; $display("FAIL upd_next12: highs=%0d want 12", highs); end
    tests_run++; if (dif.duty_ready !== 1'b1) begin tests_failed++; $display("FAIL upd_ready: got %b want 1", dif.duty_ready); end
    run_period(highs, pulses);
    tests_run++; if (highs != 12) begin tests_failed++; $display("FAIL upd_ignore3: highs=%0d want 12", highs); end
  endtask

  task automatic test_bypass();
    int highs, pulses;
    tests_run++; if (dif.duty_ready !== 1'b1) begin tests_failed++; $display("FAIL byp_ready_pre: got %b want 1", dif.duty_ready); end
    dif.duty_in = 4'd9; dif.duty_valid = 1'b1;
    step();
    dif.duty_valid = 1'b0;
    highs = (pwm_out === 1'b1) ? 1 : 0;
    tests_run++; if (dif.duty_ready !== 1'b1) begin tests_failed++; $display("FAIL byp_ready: got %b want 1", dif.duty_ready); end
    for (int i = 0; i < 15; i++) begin step(); if (pwm_out === 1'b1) highs++; end
    tests_run++; if (highs != 9) begin tests_failed++; $display("FAIL byp_duty9: highs=%0d want 9", highs); end
    run_period(highs, pulses);
    tests_run++; if (highs != 9) begin tests_failed++; $display("FAIL byp_hold9: highs=%0d want 9", highs); end
  endtask

  task automatic test_stop();
    int highs, pulses;
    highs = 0;
    for (int i = 0; i < 4; i++) begin step(); if (pwm_out === 1'b1) highs++; end
    enable = 1'b0;
    step(); if (pwm_out === 1'b1) highs++;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL stop_busy: got %b want 1", busy); end
    for (int i = 0; i < 2; i++) begin step(); if (pwm_out === 1'b1) highs++; end
    enable = 1'b1;
    for (int i = 0; i < 9; i++) begin step(); if (pwm_out === 1'b1) highs++; end
    tests_run++; if (highs != 9) begin tests_failed++; $display("FAIL stop_resume_cur: highs=%0d want 9", highs); end
    run_period(highs, pulses);
    tests_run++; if (highs != 9) begin tests_failed++; $display("FAIL stop_resume_nogap: highs=%0d want 9", highs); end
    highs = 0;
    for (int i = 0; i < 4; i++) begin step(); if (pwm_out === 1'b1) highs++; end
    enable = 1'b0;
    for (int i = 0; i < 12; i++) begin step(); if (pwm_out === 1'b1) highs++; end
    tests_run++; if (highs != 9) begin tests_failed++; $display("FAIL stop_finish: highs=%0d want 9", highs); end
    run_period(highs, pulses);
    tests_run++; if (highs != 0) begin tests_failed++; $display("FAIL stop_idle_pwm: highs=%0d want 0", highs); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL stop_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int highs, pulses;
    repeat (3) step();
    dif.duty_in = 4'd12; dif.duty_valid = 1'b1;
    step();
    dif.duty_valid = 1'b0;
    enable = 1'b1;
    align();
    repeat (2) step();
    dif.duty_in = 4'd7; dif.duty_valid = 1'b1;
    step();
    dif.duty_valid = 1'b0;
    repeat (2) step();
    tests_run++; if (pwm_out !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_pwm: got %b want 1 (q=%0d)", pwm_out, s_q); end
    tests_run++; if (dif.duty_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_pre_pend: ready=%b want 0", dif.duty_ready); end
    #2 reset_n = 1'b0;
    #1;
    tests_run++; if (pwm_out !== 1'b0) begin tests_failed++; $display("FAIL rst_async_pwm: got %b want 0", pwm_out); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_async_busy: got %b want 0", busy); end
    tests_run++; if (dif.duty_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_async_ready: got %b want 1", dif.duty_ready); end
`ifdef PWM_PERIOD_CNT_EN
    tests_run++; if (period_cnt !== 8'd0) begin tests_failed++; $display("FAIL rst_period_cnt: got %0d want 0", period_cnt); end
`endif
    #1 reset_n = 1'b1;
    step();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_rearm: busy=%b want 1", busy); end
    align();
    run_period(highs, pulses);
    tests_run++; if (highs != 0) begin tests_failed++; $display("FAIL rst_duty_cleared: highs=%0d want 0", highs); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rst_run_busy: got %b want 1", busy); end
  endtask

`ifdef PWM_PERIOD_CNT_EN
  task automatic test_period_cnt();
    int highs, pulses;
    tests_run++; if (period_cnt !== 8'd0) begin tests_failed++; $display("FAIL pcnt_start: got %0d want 0", period_cnt); end
    for (int p = 0; p < 255; p++) run_period(highs, pulses);
    tests_run++; if (period_cnt !== 8'd255) begin tests_failed++; $display("FAIL pcnt_255: got %0d want 255", period_cnt); end
    run_period(highs, pulses);
    tests_run++; if (period_cnt !== 8'd0) begin tests_failed++; $display("FAIL pcnt_rollover: got %0d want 0", period_cnt); end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_idle();
    test_run();
    test_update();
    test_bypass();
    test_stop();
    test_reset_mid();
`ifdef PWM_PERIOD_CNT_EN
    test_period_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
